// File: rtl/pipe_controller_pkg.sv
// Shared widths, opcode/ALU encodings and the control payloads carried down the
// pipeline by pipe_controller.
package pipe_controller_pkg;

   localparam int unsigned OP_W    = 6;
   localparam int unsigned REG_W   = 5;
   localparam int unsigned ALUOP_W = 4;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
   localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
   localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
   localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
   localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

   localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
   localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
   localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);
   localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3);
   localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(4);
   localparam logic [ALUOP_W-1:0] ALU_SLTU  = ALUOP_W'(5);
   localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(6);
   localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(7);
   localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(8);

   // Full decoded bundle as produced in ID
   typedef struct packed {
      logic               regwrite;
      logic               regdst;
      logic               alusrc;
      logic               branch;
      logic               bne;
      logic               memwrite;
      logic               memtoreg;
      logic               jump;
      logic [ALUOP_W-1:0] aluop;
   } ctrl_t;

   // Per-stage payloads keep only what later stages still consume
   typedef struct packed {
      logic               regwrite;
      logic               regdst;
      logic               alusrc;
      logic               branch;
      logic               bne;
      logic               memwrite;
      logic               memtoreg;
      logic [ALUOP_W-1:0] aluop;
      logic [REG_W-1:0]   writereg;
   } ex_stage_t;

   typedef struct packed {
      logic             regwrite;
      logic             memwrite;
      logic             memtoreg;
      logic [REG_W-1:0] writereg;
   } mem_stage_t;

   typedef struct packed {
      logic             regwrite;
      logic             memtoreg;
      logic [REG_W-1:0] writereg;
   } wb_stage_t;

endpackage

// File: rtl/pipe_controller_if.sv
// Datapath <-> controller signal bundle; the datapath is the master side.
interface pipe_controller_if;
   import pipe_controller_pkg::*;

   logic [OP_W-1:0]    op_d;
   logic [REG_W-1:0]   rs_d;
   logic [REG_W-1:0]   rt_d;
   logic [REG_W-1:0]   rd_d;
   logic               valid_d;
   logic               zero_e;

   logic               stall_f;
   logic               stall_d;
   logic               flush_d;
   logic               pcsrc_e;
   logic               jump_d;
   logic               alusrc_e;
   logic               regdst_e;
   logic [ALUOP_W-1:0] aluop_e;
   logic               memwrite_m;
   logic               memtoreg_m;
   logic               regwrite_m;
   logic               memtoreg_w;
   logic               regwrite_w;
   logic [REG_W-1:0]   writereg_e;
   logic [REG_W-1:0]   writereg_m;
   logic [REG_W-1:0]   writereg_w;
   logic               illegal_d;

   modport master (
      output op_d, rs_d, rt_d, rd_d, valid_d, zero_e,
      input  stall_f, stall_d, flush_d, pcsrc_e, jump_d,
      input  alusrc_e, regdst_e, aluop_e,
      input  memwrite_m, memtoreg_m, regwrite_m, memtoreg_w, regwrite_w,
      input  writereg_e, writereg_m, writereg_w, illegal_d
   );

   modport slave (
      input  op_d, rs_d, rt_d, rd_d, valid_d, zero_e,
      output stall_f, stall_d, flush_d, pcsrc_e, jump_d,
      output alusrc_e, regdst_e, aluop_e,
      output memwrite_m, memtoreg_m, regwrite_m, memtoreg_w, regwrite_w,
      output writereg_e, writereg_m, writereg_w, illegal_d
   );

endinterface

// File: rtl/pipe_controller_main_decoder.sv
// Combinational ID-stage decode of the opcode into the control bundle, plus
// the illegal-opcode flag and whether the instruction reads rt.
module main_decoder
   import pipe_controller_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   output ctrl_t           ctrl_o,
   output logic            illegal_o,
   output logic            uses_rt_o
);

   always_comb begin
      ctrl_o    = '0;
      illegal_o = 1'b0;
      uses_rt_o = 1'b0;
      case (op_i)
         OP_RTYPE: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.regdst   = 1'b1;
            ctrl_o.aluop    = ALU_FUNCT;
            uses_rt_o       = 1'b1;
         end
         OP_LW: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.memtoreg = 1'b1;
            ctrl_o.aluop    = ALU_ADD;
         end
         OP_SW: begin
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.memwrite = 1'b1;
            ctrl_o.aluop    = ALU_ADD;
            uses_rt_o       = 1'b1;
         end
         OP_BEQ: begin
            ctrl_o.branch = 1'b1;
            ctrl_o.aluop  = ALU_SUB;
            uses_rt_o     = 1'b1;
         end
         OP_BNE: begin
            ctrl_o.branch = 1'b1;
            ctrl_o.bne    = 1'b1;
            ctrl_o.aluop  = ALU_SUB;
            uses_rt_o     = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_ADD;
         end
         OP_ORI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_OR;
         end
         OP_SLTI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_SLT;
         end
         OP_SLTIU: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_SLTU;
         end
         OP_LUI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_LUI;
         end
         OP_ANDI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_AND;
         end
         OP_XORI: begin
            ctrl_o.regwrite = 1'b1;
            ctrl_o.alusrc   = 1'b1;
            ctrl_o.aluop    = ALU_XOR;
         end
         OP_J: begin
            ctrl_o.jump = 1'b1;
         end
         default: begin
            illegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/pipe_controller.sv
// 5-stage MIPS pipeline controller: ID decode, ID/EX -> EX/MEM -> MEM/WB control
// registers, load-use stall, EX branch resolution and ID jump.
module pipe_controller
   import pipe_controller_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   pipe_controller_if.slave bus
);

   ctrl_t            dec_ctrl;
   logic             dec_illegal;
   logic             dec_uses_rt;

   ex_stage_t        ex_q,  ex_d;
   mem_stage_t       mem_q, mem_d;
   wb_stage_t        wb_q,  wb_d;

   logic [REG_W-1:0] writereg_id;
   logic             lw_e;
   logic             load_use;
   logic             pcsrc;
   logic             stall;
   logic             jump;
   logic             issue;

   main_decoder u_main_decoder (
      .op_i      (bus.op_d),
      .ctrl_o    (dec_ctrl),
      .illegal_o (dec_illegal),
      .uses_rt_o (dec_uses_rt)
   );

   // Hazard and redirect resolution; a taken branch outranks the stall, which outranks the jump
   always_comb begin
      writereg_id = dec_ctrl.regdst ? bus.rd_d : bus.rt_d;
      lw_e        = ex_q.regwrite & ex_q.memtoreg;
      load_use    = lw_e & bus.valid_d & (ex_q.writereg != '0) &
                    ((ex_q.writereg == bus.rs_d) |
                     ((ex_q.writereg == bus.rt_d) & dec_uses_rt));
      pcsrc       = ex_q.branch & (bus.zero_e ^ ex_q.bne);
      stall       = load_use & ~pcsrc;
      jump        = dec_ctrl.jump & bus.valid_d & ~pcsrc & ~stall;
      issue       = bus.valid_d & ~stall & ~pcsrc & ~dec_illegal;
   end

   // Next-state for each pipeline register; anything not issued becomes a bubble
   always_comb begin
      ex_d = '0;
      if (issue) begin
         ex_d.regwrite = dec_ctrl.regwrite;
         ex_d.regdst   = dec_ctrl.regdst;
         ex_d.alusrc   = dec_ctrl.alusrc;
         ex_d.branch   = dec_ctrl.branch;
         ex_d.bne      = dec_ctrl.bne;
         ex_d.memwrite = dec_ctrl.memwrite;
         ex_d.memtoreg = dec_ctrl.memtoreg;
         ex_d.aluop    = dec_ctrl.aluop;
         ex_d.writereg = writereg_id;
      end

      mem_d          = '0;
      mem_d.regwrite = ex_q.regwrite;
      mem_d.memwrite = ex_q.memwrite;
      mem_d.memtoreg = ex_q.memtoreg;
      mem_d.writereg = ex_q.writereg;

      wb_d          = '0;
      wb_d.regwrite = mem_q.regwrite;
      wb_d.memtoreg = mem_q.memtoreg;
      wb_d.writereg = mem_q.writereg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign bus.stall_f    = stall;
   assign bus.stall_d    = stall;
   assign bus.flush_d    = pcsrc | jump;
   assign bus.pcsrc_e    = pcsrc;
   assign bus.jump_d     = jump;
   assign bus.illegal_d  = dec_illegal;

   assign bus.alusrc_e   = ex_q.alusrc;
   assign bus.regdst_e   = ex_q.regdst;
   assign bus.aluop_e    = ex_q.aluop;
   assign bus.writereg_e = ex_q.writereg;

   assign bus.memwrite_m = mem_q.memwrite;
   assign bus.memtoreg_m = mem_q.memtoreg;
   assign bus.regwrite_m = mem_q.regwrite;
   assign bus.writereg_m = mem_q.writereg;

   assign bus.memtoreg_w = wb_q.memtoreg;
   assign bus.regwrite_w = wb_q.regwrite;
   assign bus.writereg_w = wb_q.writereg;

endmodule

// File: tb/tb_pipe_controller.sv
// Self-checking bench for pipe_controller: directed scenarios plus a randomized
// run against a table-driven reference pipeline.
module tb_pipe_controller;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pipe_controller_if bus_if ();

   pipe_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference decode table: {regwrite,regdst,alusrc,branch,bne,memwrite,memtoreg,jump,aluop[3:0],uses_rt}
   logic [5:0]  ops [14] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b001000, 6'b001001, 6'b001101, 6'b001010, 6'b001011,
                             6'b001111, 6'b001100, 6'b001110, 6'b000010};
   logic [12:0] fld [14] = '{13'b1_1_0_0_0_0_0_0_0010_1,   // RTYPE
                             13'b1_0_1_0_0_0_1_0_0000_0,   // LW
                             13'b0_0_1_0_0_1_0_0_0000_1,   // SW
                             13'b0_0_0_1_0_0_0_0_0001_1,   // BEQ
                             13'b0_0_0_1_1_0_0_0_0001_1,   // BNE
                             13'b1_0_1_0_0_0_0_0_0000_0,   // ADDI
                             13'b1_0_1_0_0_0_0_0_0000_0,   // ADDIU
                             13'b1_0_1_0_0_0_0_0_0011_0,   // ORI
                             13'b1_0_1_0_0_0_0_0_0100_0,   // SLTI
                             13'b1_0_1_0_0_0_0_0_0101_0,   // SLTIU
                             13'b1_0_1_0_0_0_0_0_0110_0,   // LUI
                             13'b1_0_1_0_0_0_0_0_0111_0,   // ANDI
                             13'b1_0_1_0_0_0_0_0_1000_0,   // XORI
                             13'b0_0_0_0_0_0_0_1_0000_0};  // J

   localparam logic [5:0] T_RTYPE = 6'b000000;
   localparam logic [5:0] T_LW    = 6'b100011;
   localparam logic [5:0] T_SW    = 6'b101011;
   localparam logic [5:0] T_BEQ   = 6'b000100;
   localparam logic [5:0] T_BNE   = 6'b000101;
   localparam logic [5:0] T_ADDI  = 6'b001000;
   localparam logic [5:0] T_J     = 6'b000010;

   typedef struct packed {
      logic       rw, rdst, asrc, br, bne, mw, m2r;
      logic [3:0] alu;
      logic [4:0] wr;
   } stg_t;

   function automatic logic [13:0] lookup(input logic [5:0] op);
      for (int k = 0; k < 14; k++)
         if (ops[k] == op) return {1'b1, fld[k]};
      return 14'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic valid, input logic zero);
      bus_if.op_d    = op;
      bus_if.rs_d    = rs;
      bus_if.rt_d    = rt;
      bus_if.rd_d    = rd;
      bus_if.valid_d = valid;
      bus_if.zero_e  = zero;
   endtask

   task automatic idle();
      drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
   endtask

   function automatic logic [25:0] regs_now();
      return {bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e,
              bus_if.memwrite_m, bus_if.memtoreg_m, bus_if.regwrite_m, bus_if.writereg_m,
              bus_if.memtoreg_w, bus_if.regwrite_w, bus_if.writereg_w};
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (regs_now() !== 26'd0) begin
         errors++;
         $display("FAIL reset_regs: got %h expected 0", regs_now());
      end
      checks++;
      if ({bus_if.stall_f, bus_if.stall_d, bus_if.flush_d, bus_if.pcsrc_e, bus_if.jump_d} !== 5'd0) begin
         errors++;
         $display("FAIL reset_hazard: got %b expected 00000",
                  {bus_if.stall_f, bus_if.stall_d, bus_if.flush_d, bus_if.pcsrc_e, bus_if.jump_d});
      end
   endtask

   task automatic test_opcode_sweep();
      logic prev_bne;
      prev_bne = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i < 14) drive(ops[i], 5'd0, 5'd0, 5'd7, 1'b1, prev_bne);
         else        drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, prev_bne);
         #1;
         checks++;
         if (bus_if.pcsrc_e !== 1'b0) begin
            errors++;
            $display("FAIL sweep_pcsrc[%0d]: got %b expected 0", i, bus_if.pcsrc_e);
         end
         prev_bne = (i < 14) && (ops[i] == T_BNE);
         tick();
         if (i < 14) begin
            checks++;
            if (bus_if.aluop_e !== fld[i][4:1]) begin
               errors++;
               $display("FAIL sweep_aluop[%0d]: got %h expected %h", i, bus_if.aluop_e, fld[i][4:1]);
            end
         end
         if (i >= 1 && i < 15) begin
            checks++;
            if (bus_if.memwrite_m !== fld[i-1][7]) begin
               errors++;
               $display("FAIL sweep_memwrite[%0d]: got %b expected %b", i-1, bus_if.memwrite_m, fld[i-1][7]);
            end
         end
         if (i >= 2) begin
            checks++;
            if (bus_if.regwrite_w !== fld[i-2][12]) begin
               errors++;
               $display("FAIL sweep_regwrite[%0d]: got %b expected %b", i-2, bus_if.regwrite_w, fld[i-2][12]);
            end
         end
      end
   endtask

   task automatic test_load_use();
      idle(); tick(); tick();
      drive(T_LW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0); tick();
      drive(T_RTYPE, 5'd8, 5'd2, 5'd3, 1'b1, 1'b0); #1;
      checks++;
      if ({bus_if.stall_f, bus_if.stall_d, bus_if.flush_d} !== 3'b110) begin
         errors++;
         $display("FAIL lu_stall: got %b expected 110", {bus_if.stall_f, bus_if.stall_d, bus_if.flush_d});
      end
      tick();
      checks++;
      if ({bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e} !== 11'd0) begin
         errors++;
         $display("FAIL lu_bubble: got %h expected 0",
                  {bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e});
      end
      checks++;
      if ({bus_if.regwrite_m, bus_if.memtoreg_m, bus_if.writereg_m, bus_if.stall_f} !== {2'b11, 5'd8, 1'b0}) begin
         errors++;
         $display("FAIL lu_after: got %h expected %h",
                  {bus_if.regwrite_m, bus_if.memtoreg_m, bus_if.writereg_m, bus_if.stall_f}, {2'b11, 5'd8, 1'b0});
      end
      idle(); tick(); tick();
      drive(T_LW, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0); tick();
      drive(T_RTYPE, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0); #1;
      checks++;
      if (bus_if.stall_f !== 1'b0) begin
         errors++;
         $display("FAIL lu_reg0: got %b expected 0", bus_if.stall_f);
      end
   endtask

   task automatic test_sw_rt();
      idle(); tick(); tick();
      drive(T_LW, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0); tick();
      drive(T_SW, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0); #1;
      checks++;
      if ({bus_if.stall_f, bus_if.stall_d} !== 2'b11) begin
         errors++;
         $display("FAIL sw_rt_stall: got %b expected 11", {bus_if.stall_f, bus_if.stall_d});
      end
      idle(); tick(); tick();
      drive(T_LW, 5'd1, 5'd9, 5'd0, 1'b1, 1'b0); tick();
      drive(T_ADDI, 5'd2, 5'd9, 5'd0, 1'b1, 1'b0); #1;
      checks++;
      if ({bus_if.stall_f, bus_if.stall_d} !== 2'b00) begin
         errors++;
         $display("FAIL addi_rt_nostall: got %b expected 00", {bus_if.stall_f, bus_if.stall_d});
      end
   endtask

   task automatic test_branch();
      idle(); tick(); tick();
      drive(T_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
      drive(T_ADDI, 5'd3, 5'd5, 5'd0, 1'b1, 1'b1); #1;
      checks++;
      if ({bus_if.pcsrc_e, bus_if.flush_d} !== 2'b11) begin
         errors++;
         $display("FAIL beq_taken: got %b expected 11", {bus_if.pcsrc_e, bus_if.flush_d});
      end
      tick();
      checks++;
      if ({bus_if.alusrc_e, bus_if.aluop_e, bus_if.writereg_e} !== 10'd0) begin
         errors++;
         $display("FAIL beq_bubble: got %h expected 0", {bus_if.alusrc_e, bus_if.aluop_e, bus_if.writereg_e});
      end
      idle(); tick(); tick();
      drive(T_BNE, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
      drive(6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1); #1;
      checks++;
      if (bus_if.pcsrc_e !== 1'b0) begin
         errors++;
         $display("FAIL bne_zero1: got %b expected 0", bus_if.pcsrc_e);
      end
      bus_if.zero_e = 1'b0; #1;
      checks++;
      if (bus_if.pcsrc_e !== 1'b1) begin
         errors++;
         $display("FAIL bne_zero0: got %b expected 1", bus_if.pcsrc_e);
      end
   endtask

   task automatic test_jump();
      idle(); tick(); tick();
      drive(T_J, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0); #1;
      checks++;
      if ({bus_if.jump_d, bus_if.flush_d, bus_if.pcsrc_e} !== 3'b110) begin
         errors++;
         $display("FAIL jump: got %b expected 110", {bus_if.jump_d, bus_if.flush_d, bus_if.pcsrc_e});
      end
      tick();
      drive(T_BEQ, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0); tick();
      drive(T_J, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1); #1;
      checks++;
      if ({bus_if.jump_d, bus_if.flush_d, bus_if.pcsrc_e} !== 3'b011) begin
         errors++;
         $display("FAIL jump_vs_branch: got %b expected 011", {bus_if.jump_d, bus_if.flush_d, bus_if.pcsrc_e});
      end
   endtask

   task automatic test_reset_inflight();
      idle(); tick(); tick();
      drive(T_LW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0); tick();
      drive(T_SW, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0); tick();
      drive(T_RTYPE, 5'd4, 5'd5, 5'd6, 1'b1, 1'b0); tick();
      checks++;
      if ({bus_if.memwrite_m, bus_if.regwrite_w, bus_if.regdst_e} !== 3'b111) begin
         errors++;
         $display("FAIL inflight_loaded: got %b expected 111", {bus_if.memwrite_m, bus_if.regwrite_w, bus_if.regdst_e});
      end
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
      checks++;
      if (regs_now() !== 26'd0) begin
         errors++;
         $display("FAIL reset_inflight: got %h expected 0", regs_now());
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({bus_if.regwrite_w, bus_if.memwrite_m, bus_if.regwrite_m} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_pulse[%0d]: got %b expected 000", c,
                     {bus_if.regwrite_w, bus_if.memwrite_m, bus_if.regwrite_m});
         end
      end
   endtask

   task automatic test_illegal();
      idle(); tick(); tick();
      drive(6'b111111, 5'd1, 5'd7, 5'd0, 1'b1, 1'b0); #1;
      checks++;
      if (bus_if.illegal_d !== 1'b1) begin
         errors++;
         $display("FAIL illegal_flag: got %b expected 1", bus_if.illegal_d);
      end
      tick();
      idle();
      checks++;
      if ({bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e} !== 11'd0) begin
         errors++;
         $display("FAIL illegal_ex: got %h expected 0", {bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e});
      end
      tick(); tick();
      checks++;
      if ({bus_if.regwrite_w, bus_if.writereg_w} !== 6'd0) begin
         errors++;
         $display("FAIL illegal_wb: got %h expected 0", {bus_if.regwrite_w, bus_if.writereg_w});
      end
   endtask

   // Randomized run against a three-entry reference pipeline built from the decode table
   task automatic test_random();
      stg_t        pipe [3];
      stg_t        nxt;
      logic [13:0] d;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd;
      logic        valid, zero, lw, lu, pc, st, jp;
      reset = 1'b1; idle(); tick(); reset = 1'b0;
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      for (int n = 0; n < 400; n++) begin
         op    = ($urandom_range(0, 14) == 14) ? 6'b111111 : ops[$urandom_range(0, 13)];
         rs    = 5'($urandom_range(0, 3));
         rt    = 5'($urandom_range(0, 3));
         rd    = 5'($urandom_range(0, 3));
         valid = ($urandom_range(0, 3) != 0);
         zero  = 1'($urandom_range(0, 1));
         drive(op, rs, rt, rd, valid, zero);
         #1;
         d  = lookup(op);
         lw = pipe[0].rw && pipe[0].m2r;
         lu = lw && valid && (pipe[0].wr != 0) &&
              ((pipe[0].wr == rs) || ((pipe[0].wr == rt) && d[0]));
         pc = pipe[0].br && (zero != pipe[0].bne);
         st = lu && !pc;
         jp = d[5] && valid && !pc && !st;
         checks++;
         if ({bus_if.stall_f, bus_if.stall_d, bus_if.flush_d, bus_if.pcsrc_e, bus_if.jump_d, bus_if.illegal_d}
             !== {st, st, pc || jp, pc, jp, !d[13]}) begin
            errors++;
            $display("FAIL rnd_id[%0d]: got %b expected %b", n,
                     {bus_if.stall_f, bus_if.stall_d, bus_if.flush_d, bus_if.pcsrc_e, bus_if.jump_d, bus_if.illegal_d},
                     {st, st, pc || jp, pc, jp, !d[13]});
         end
         checks++;
         if ({bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e}
             !== {pipe[0].asrc, pipe[0].rdst, pipe[0].alu, pipe[0].wr}) begin
            errors++;
            $display("FAIL rnd_ex[%0d]: got %h expected %h", n,
                     {bus_if.alusrc_e, bus_if.regdst_e, bus_if.aluop_e, bus_if.writereg_e},
                     {pipe[0].asrc, pipe[0].rdst, pipe[0].alu, pipe[0].wr});
         end
         checks++;
         if ({bus_if.memwrite_m, bus_if.memtoreg_m, bus_if.regwrite_m, bus_if.writereg_m}
             !== {pipe[1].mw, pipe[1].m2r, pipe[1].rw, pipe[1].wr}) begin
            errors++;
            $display("FAIL rnd_mem[%0d]: got %h expected %h", n,
                     {bus_if.memwrite_m, bus_if.memtoreg_m, bus_if.regwrite_m, bus_if.writereg_m},
                     {pipe[1].mw, pipe[1].m2r, pipe[1].rw, pipe[1].wr});
         end
         checks++;
         if ({bus_if.memtoreg_w, bus_if.regwrite_w, bus_if.writereg_w}
             !== {pipe[2].m2r, pipe[2].rw, pipe[2].wr}) begin
            errors++;
            $display("FAIL rnd_wb[%0d]: got %h expected %h", n,
                     {bus_if.memtoreg_w, bus_if.regwrite_w, bus_if.writereg_w},
                     {pipe[2].m2r, pipe[2].rw, pipe[2].wr});
         end
         nxt = '0;
         if (valid && !st && !pc && d[13]) begin
            nxt.rw   = d[12];
            nxt.rdst = d[11];
            nxt.asrc = d[10];
            nxt.br   = d[9];
            nxt.bne  = d[8];
            nxt.mw   = d[7];
            nxt.m2r  = d[6];
            nxt.alu  = d[4:1];
            nxt.wr   = d[11] ? rd : rt;
         end
         tick();
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = nxt;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      idle();
      test_reset();
      test_opcode_sweep();
      test_load_use();
      test_sw_rt();
      test_branch();
      test_jump();
      test_reset_inflight();
      test_illegal();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_controller.md
Name: pipe_controller

Overview:
- Pipelined successor to the single-cycle main decoder. Decodes the 6-bit opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and raises stall/flush for the 5-stage MIPS pipeline.
- Resolves jumps in ID and conditional branches in EX.
- Sits beside the datapath. Drives its mux selects and pipeline-register enables.

Parameters:
- OP_W, 6, opcode width.
- REG_W, 5, register address width.
- ALUOP_W, 4, ALU operation code width (minimum 4).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op_d  in  OP_W  opcode of the instruction in ID.
- rs_d, rt_d, rd_d  in  REG_W each  source/destination fields in ID.
- valid_d  in  1  ID holds a real instruction.
- zero_e  in  1  ALU zero flag in EX.
- stall_f, stall_d  out  1 each  hold PC and IF/ID.
- flush_d  out  1  clear IF/ID.
- pcsrc_e  out  1  take the branch target.
- jump_d  out  1  take the jump target.
- alusrc_e, regdst_e  out  1 each  EX mux selects.
- aluop_e  out  ALUOP_W  EX ALU operation.
- memwrite_m, memtoreg_m, regwrite_m  out  1 each  MEM-stage controls.
- memtoreg_w, regwrite_w  out  1 each  WB-stage controls.
- writereg_e, writereg_m, writereg_w  out  REG_W each  destination register per stage.
- illegal_d  out  1  opcode in ID is not decoded.

Behaviour:
- Decode (combinational, ID stage), opcodes as fields {regwrite, regdst, alusrc, branch, bne, memwrite, memtoreg, jump, aluop}:
  - RTYPE 000000: 1,1,0,0,0,0,0,0,0010.
  - LW 100011: 1,0,1,0,0,0,1,0,0000.
  - SW 101011: 0,x,1,0,0,1,0,0,0000.
  - BEQ 000100: branch=1, aluop 0001.
  - BNE 000101: branch=1, bne=1, aluop 0001.
  - ADDI 001000 and ADDIU 001001: regwrite, alusrc, aluop 0000.
  - ORI 001101: aluop 0011.
  - SLTI 001010: aluop 0100.
  - SLTIU 001011: aluop 0101.
  - LUI 001111: aluop 0110.
  - ANDI 001100: aluop 0111.
  - XORI 001110: aluop 1000.
  - All immediate ops above: regwrite=1, alusrc=1.
  - J 000010: jump=1 only.
  - All x fields drive 0.
  - Any other opcode: illegal_d=1 and all fields 0. No trap is taken.
- Write register: rd_d when regdst=1, else rt_d.
- uses_rt: asserted for RTYPE, SW, BEQ and BNE.
- Load-use hazard: lw_e = regwrite_e & memtoreg_e. Raise stall_f = stall_d = 1 when lw_e, valid_d, and writereg_e != 0, and writereg_e equals rs_d, or equals rt_d with uses_rt asserted. The same cycle, ID/EX loads a bubble (all controls 0, writereg 0).
- Branch, EX stage: pcsrc_e = branch_e & (zero_e ^ bne_e), combinational.
- Branch taken: flush_d=1 and ID/EX loads a bubble at the next edge.
- Jump: jump_d = decoded jump & valid_d & ~pcsrc_e. It asserts flush_d and is not inserted into ID/EX as a control.
- Priority when events coincide: pcsrc_e over stall over jump.
  - A taken branch in the same cycle as a load-use condition deasserts both stall outputs.
  - Both cases flush.
- Invalid cycles: valid_d=0 inserts a bubble and suppresses hazard outputs.
- Pipeline registers: ID/EX → EX/MEM → MEM/WB advance every cycle and have no enable. Latency from ID decode to the WB control is 3 cycles.
- Reset, at the clk edge with reset=1: all pipeline registers clear to bubbles. Every registered output reads 0 on the next cycle.
- Reset mid-operation: in-flight controls are discarded. No writeback from pre-reset instructions after the edge.
- Widths: aluop is zero-extended to ALUOP_W.

Decomposition:
- Shared package: opcode localparams (OP_RTYPE … OP_XORI), ALUOP encodings (ALU_ADD=0, ALU_SUB=1, ALU_FUNCT=2, ALU_OR=3, ALU_SLT=4, ALU_SLTU=5, ALU_LUI=6, ALU_AND=7, ALU_XOR=8), and a packed control-bundle typedef.
- Sub-module: main_decoder, combinational op → control bundle and illegal flag.
- The top level holds the pipeline registers and hazard logic.

Test Plan:
- Opcode sweep: apply each of the 14 opcodes one per cycle with valid_d=1, no hazards. After 1 cycle, aluop_e matches the table. After 2 cycles, memwrite_m=1 only for SW. After 3 cycles, regwrite_w=1 only for RTYPE, LW and the immediate ops.
- Load-use stall: LW writing $8 goes to EX while RTYPE with rs_d=8 is in ID. Expect stall_f=stall_d=1 for one cycle and an all-zero bubble in ID/EX. Repeat with writereg_e=0 and expect no stall.
- SW rt dependence versus ADDI: LW writing $9 with SW rt_d=9 in ID → stall. LW writing $9 with ADDI rt_d=9 (rt is the destination) → no stall.
- Branch cases: BEQ in EX with zero_e=1 → pcsrc_e=1, flush_d=1, and ID/EX is a bubble next cycle. BNE with zero_e=1 → pcsrc_e=0. BNE with zero_e=0 → pcsrc_e=1.
- Jump and coincidence: J in ID → jump_d=1, flush_d=1. J in ID coinciding with a taken branch in EX → jump_d=0, pcsrc_e=1. A taken branch coinciding with a load-use condition → stall outputs=0.
- Reset and illegal opcode: assert reset for one edge while LW, SW and RTYPE are in flight. On the next cycle every registered output is 0, and no regwrite_w or memwrite_m pulse follows. Separately, op_d=111111 → illegal_d=1 and a bubble propagates.
